irq_priority_in_service: RTL and testbench

Upstream partner of the 8259 control logic. It holds the interrupt request register (IRR), priority resolver and in-service register (ISR) for IR0-IR7.
- Samples the raw IR pins and applies masking and rotating priority.
- Presents the winning one-hot request to the control logic on `interrupt`.
- Consumes the control logic's latch_in_service, end_of_interrupt, clear_interrupt_request, freeze, interrupt_mask, priority_rotate and trigger-mode outputs.

---
 rtl/irq_priority_in_service.sv | 115 +++++++++++
 tb/tb_irq_priority_in_service.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_in_service.sv
// IRR, priority resolver and ISR for IR0-IR7 of an 8259-style interrupt controller.
// Feeds the one-hot winning request to the control logic and tracks in-service levels.
module irq_priority_in_service #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] interrupt_request_pin,
   input  logic       level_or_edge_triggered_config,
   input  logic       freeze,
   input  logic [7:0] clear_interrupt_request,
   input  logic [7:0] interrupt_mask,
   input  logic [2:0] priority_rotate,
   input  logic       latch_in_service,
   input  logic [7:0] end_of_interrupt,
   output logic [7:0] interrupt,
   output logic [7:0] highest_level_in_service,
   output logic [7:0] interrupt_request_register,
   output logic [7:0] in_service_register
);

   localparam int unsigned NUM_IRQ = 8;

   logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
   logic [NUM_IRQ-1:0] s;
   logic [NUM_IRQ-1:0] p;
   logic [NUM_IRQ-1:0] rise_q;
   logic [NUM_IRQ-1:0] irr;
   logic [NUM_IRQ-1:0] isr;
   logic [NUM_IRQ-1:0] irr_next;
   logic [NUM_IRQ-1:0] req;
   logic [NUM_IRQ-1:0] winner;
   logic [NUM_IRQ-1:0] resolved;

   // One-hot of the first set bit of vec, scanning from lowest+1 cyclically down to lowest.
   function automatic logic [NUM_IRQ-1:0] first_in_order(input logic [NUM_IRQ-1:0] vec,
                                                          input logic [2:0] lowest);
      logic [2:0] lvl;
      logic       found;
      first_in_order = '0;
      found          = 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         lvl = lowest + 3'd1 + 3'(i);
         if (!found && vec[lvl]) begin
            found               = 1'b1;
            first_in_order[lvl] = 1'b1;
         end
      end
   endfunction

   // Pin synchronizer chain.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= interrupt_request_pin;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Edge mode: a rising edge of s is captured a cycle after p catches up, then requests.
   always_comb begin
      irr_next = '0;
      if (level_or_edge_triggered_config) begin
         irr_next = s & ~clear_interrupt_request;
      end else begin
         irr_next = s & (irr | rise_q) & ~clear_interrupt_request;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         p      <= '0;
         rise_q <= '0;
         irr    <= '0;
      end else begin
         p      <= s;
         rise_q <= s & ~p;
         irr    <= irr_next;
      end
   end

   // An in-service level at or above the top request blocks the whole resolver.
   always_comb begin
      req      = irr & ~interrupt_mask;
      winner   = first_in_order(req | isr, priority_rotate);
      resolved = ((winner & isr) != '0) ? '0 : winner;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         interrupt <= '0;
      end else if (!freeze) begin
         interrupt <= resolved;
      end
   end

   // A latch on the same bit as an EOI wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         isr <= '0;
      end else begin
         isr <= (isr & ~end_of_interrupt) | (latch_in_service ? interrupt : '0);
      end
   end

   assign highest_level_in_service   = first_in_order(isr, priority_rotate);
   assign interrupt_request_register = irr;
   assign in_service_register        = isr;

endmodule

// File: tb/tb_irq_priority_in_service.sv
// Scoreboard bench for irq_priority_in_service: directed stimulus queues expectations
// tagged with a due cycle; a negedge monitor compares them against the outputs.
module tb_irq_priority_in_service;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int SEL_INT  = 0;
   localparam int SEL_HLIS = 1;
   localparam int SEL_IRR  = 2;
   localparam int SEL_ISR  = 3;

   typedef struct {
      string      name;
      int         sel;
      logic [7:0] exp;
      int         due;
   } chk_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] pin;
   logic       level_cfg;
   logic       freeze;
   logic [7:0] clr;
   logic [7:0] mask;
   logic [2:0] rot;
   logic       latch;
   logic [7:0] eoi;
   logic [7:0] interrupt;
   logic [7:0] hlis;
   logic [7:0] irr;
   logic [7:0] isr;

   int   cyc = 0;
   int   applied = 0;
   int   miscompares = 0;
   chk_t sb[$];
   chk_t keep[$];

   irq_priority_in_service #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clock                          (clock),
      .reset                          (reset),
      .interrupt_request_pin          (pin),
      .level_or_edge_triggered_config (level_cfg),
      .freeze                         (freeze),
      .clear_interrupt_request        (clr),
      .interrupt_mask                 (mask),
      .priority_rotate                (rot),
      .latch_in_service               (latch),
      .end_of_interrupt               (eoi),
      .interrupt                      (interrupt),
      .highest_level_in_service       (hlis),
      .interrupt_request_register     (irr),
      .in_service_register            (isr)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [7:0] observe(input int sel);
      case (sel)
         SEL_INT:  observe = interrupt;
         SEL_HLIS: observe = hlis;
         SEL_IRR:  observe = irr;
         default:  observe = isr;
      endcase
   endfunction

   // Monitor: compare every expectation whose due cycle has arrived.
   always @(negedge clock) begin
      logic [7:0] act;
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].due == cyc) begin
            act = observe(sb[i].sel);
            applied++;
            if (act !== sb[i].exp) begin
               miscompares++;
               $display("FAIL %s (cycle %0d): got %02h, expected %02h", sb[i].name, cyc, act, sb[i].exp);
            end
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Expect sel == exp after lat more rising edges (0 = current cycle).
   task automatic chk(input string name, input int sel, input logic [7:0] exp, input int lat);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      c.due  = cyc + lat;
      sb.push_back(c);
   endtask

   task automatic do_reset(input logic level);
      pin = '0; freeze = 0; clr = '0; mask = '0; rot = 3'd7; latch = 0; eoi = '0;
      level_cfg = level;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      pin = '0; level_cfg = 0; freeze = 0; clr = '0; mask = '0; rot = 3'd7; latch = 0; eoi = '0;
      do_reset(1'b0);
      applied++;
      if (irr !== 8'h00) begin
         miscompares++;
         $display("FAIL rst_irr_direct: got %02h, expected 00", irr);
      end
      applied++;
      if (isr !== 8'h00) begin
         miscompares++;
         $display("FAIL rst_isr_direct: got %02h, expected 00", isr);
      end
      applied++;
      if (interrupt !== 8'h00) begin
         miscompares++;
         $display("FAIL rst_int_direct: got %02h, expected 00", interrupt);
      end
      applied++;
      if (hlis !== 8'h00) begin
         miscompares++;
         $display("FAIL rst_hlis_direct: got %02h, expected 00", hlis);
      end
      chk("rst_irr", SEL_IRR, 8'h00, 0);
      chk("rst_isr", SEL_ISR, 8'h00, 0);
      chk("rst_int", SEL_INT, 8'h00, 0);
      chk("rst_hlis", SEL_HLIS, 8'h00, 0);
      step(1);

      // 1: edge-mode IR3, SYNC_STAGES+2 edges to IRR, one more to interrupt, then latch.
      pin = 8'h08;
      chk("t1_irr_early", SEL_IRR, 8'h00, 3);
      chk("t1_irr", SEL_IRR, 8'h08, 4);
      chk("t1_int_early", SEL_INT, 8'h00, 4);
      chk("t1_int", SEL_INT, 8'h08, 5);
      step(5);
      latch = 1;
      chk("t1_isr", SEL_ISR, 8'h08, 1);
      chk("t1_hlis", SEL_HLIS, 8'h08, 1);
      chk("t1_int_blocked", SEL_INT, 8'h00, 2);
      step(1);
      latch = 0;
      step(1);

      // 2: IR5 blocked by in-service IR3; IR1 outranks it; EOI keeps IR1 winning.
      pin = 8'h28;
      chk("t2_irr_ir5", SEL_IRR, 8'h28, 4);
      chk("t2_int_ir5_blocked", SEL_INT, 8'h00, 6);
      step(6);
      pin = 8'h2A;
      chk("t2_irr_ir1", SEL_IRR, 8'h2A, 4);
      chk("t2_int_ir1", SEL_INT, 8'h02, 5);
      step(5);
      eoi = 8'h08;
      chk("t2_isr_eoi", SEL_ISR, 8'h00, 1);
      chk("t2_hlis_eoi", SEL_HLIS, 8'h00, 1);
      chk("t2_int_after_eoi", SEL_INT, 8'h02, 2);
      step(1);
      eoi = '0;
      step(1);

      // 3: rotation and masking in level mode.
      do_reset(1'b1);
      applied++;
      if (isr !== 8'h00) begin
         miscompares++;
         $display("FAIL t3_rst_isr_direct: got %02h, expected 00", isr);
      end
      applied++;
      if (interrupt !== 8'h00) begin
         miscompares++;
         $display("FAIL t3_rst_int_direct: got %02h, expected 00", interrupt);
      end
      rot = 3'd2;
      pin = 8'h09;
      chk("t3_irr", SEL_IRR, 8'h09, 3);
      chk("t3_int_rot2", SEL_INT, 8'h08, 4);
      step(4);
      mask = 8'h08;
      chk("t3_int_mask", SEL_INT, 8'h01, 1);
      chk("t3_irr_unmasked", SEL_IRR, 8'h09, 1);
      step(1);
      mask = 8'h00; rot = 3'd0;
      chk("t3_int_rot0", SEL_INT, 8'h08, 1);
      step(1);
      rot = 3'd3;
      chk("t3_int_rot3", SEL_INT, 8'h01, 1);
      step(1);

      // 4: freeze holds the resolver output; level IRR follows the pin.
      do_reset(1'b1);
      pin = 8'h40;
      chk("t4_irr", SEL_IRR, 8'h40, 3);
      chk("t4_int", SEL_INT, 8'h40, 4);
      step(4);
      freeze = 1; pin = 8'h44;
      chk("t4_irr_ir2", SEL_IRR, 8'h44, 3);
      chk("t4_int_frozen_a", SEL_INT, 8'h40, 4);
      chk("t4_int_frozen_b", SEL_INT, 8'h40, 5);
      step(5);
      freeze = 0;
      chk("t4_int_unfrozen", SEL_INT, 8'h04, 1);
      step(1);
      pin = 8'h40;
      chk("t4_irr_hold", SEL_IRR, 8'h44, 2);
      chk("t4_irr_drop", SEL_IRR, 8'h40, 3);
      chk("t4_int_drop", SEL_INT, 8'h40, 4);
      step(4);

      // 5: clear coinciding with the edge-mode capture wins, and no re-request while held.
      do_reset(1'b0);
      pin = 8'h10;
      step(3);
      clr = 8'h10;
      chk("t5_irr_clr", SEL_IRR, 8'h00, 1);
      chk("t5_irr_held_a", SEL_IRR, 8'h00, 2);
      chk("t5_int_clr", SEL_INT, 8'h00, 3);
      chk("t5_irr_held_b", SEL_IRR, 8'h00, 5);
      step(1);
      clr = '0;
      step(5);
      level_cfg = 1;
      chk("t5_lvl_irr", SEL_IRR, 8'h10, 1);
      step(1);
      clr = 8'h10;
      chk("t5_lvl_clr", SEL_IRR, 8'h00, 1);
      chk("t5_lvl_reassert", SEL_IRR, 8'h10, 2);
      step(1);
      clr = '0;
      step(1);

      // 6: latch beats same-cycle EOI; reset mid-sequence clears everything.
      do_reset(1'b1);
      pin = 8'h20;
      chk("t6_int", SEL_INT, 8'h20, 4);
      step(4);
      latch = 1; eoi = 8'h20;
      chk("t6_isr_latch_wins", SEL_ISR, 8'h20, 1);
      chk("t6_hlis", SEL_HLIS, 8'h20, 1);
      step(1);
      latch = 0; eoi = '0;
      reset = 1;
      chk("t6_rst_irr", SEL_IRR, 8'h00, 1);
      chk("t6_rst_isr", SEL_ISR, 8'h00, 1);
      chk("t6_rst_int", SEL_INT, 8'h00, 1);
      chk("t6_rst_hlis", SEL_HLIS, 8'h00, 1);
      step(1);
      reset = 0;
      chk("t6_resample_early", SEL_IRR, 8'h00, 2);
      chk("t6_resample", SEL_IRR, 8'h20, 3);
      step(6);

      foreach (sb[i]) begin
         miscompares++;
         $display("FAIL %s: never compared, expected %02h", sb[i].name, sb[i].exp);
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
